// File: rtl/imm_pkg.sv
// Shared immediate-mode encodings, reused by instruction decode and the immediate stage.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'b00,
    IMM_ZERO   = 2'b01,
    IMM_SHL    = 2'b10,
    IMM_PREFIX = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: narrow (IMM_W) or prefixed (2*IMM_W) operand to DATA_W by mode.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int NIB_W  = 4,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic [4*NIB_W-1:0] op,
  input  logic               wide,
  input  imm_mode_e          mode,
  output logic [DATA_W-1:0]  value
);

  localparam int IMM_W = 2 * NIB_W;
  localparam int OP_W  = 2 * IMM_W;

  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic              sign_bit;
  int                op_bits;

  always_comb begin
    zext     = '0;
    op_bits  = wide ? OP_W : IMM_W;
    sign_bit = wide ? op[OP_W-1] : op[IMM_W-1];
    if (wide) zext[OP_W-1:0] = op;
    else      zext[IMM_W-1:0] = op[IMM_W-1:0];

    // Replicate the operand MSB into every bit above the active operand width.
    sext = zext;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= op_bits) sext[i] = sign_bit;
    end
  end

  always_comb begin
    value = zext;
    case (mode)
      IMM_SIGN: value = sext;
      IMM_ZERO: value = zext;
      IMM_SHL:  value = zext << SHIFT;
      default:  value = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate stage: prefix register, one-entry output register and valid/ready handshake.
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int NIB_W  = 4,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  imm_high,
  input  logic [NIB_W-1:0]  imm_low,
  input  logic [1:0]        mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              prefix_pending,
  output logic              prefix_overrun
);

  localparam int IMM_W = 2 * NIB_W;

  if (DATA_W < 2 * IMM_W) begin : g_bad_data_w
    $error("imm_extend_unit: DATA_W must be at least 2*IMM_W");
  end
  if (SHIFT < 0 || SHIFT >= DATA_W) begin : g_bad_shift
    $error("imm_extend_unit: SHIFT must lie in [0, DATA_W)");
  end

  imm_mode_e         mode_e;
  logic [IMM_W-1:0]  imm8;
  logic [IMM_W-1:0]  prefix_reg;
  logic [2*IMM_W-1:0] op;
  logic [DATA_W-1:0] ext_value;
  logic              accept;

  assign mode_e   = imm_mode_e'(mode);
  assign imm8     = {imm_high, imm_low};
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op       = prefix_pending ? {prefix_reg, imm8} : {{IMM_W{1'b0}}, imm8};

  imm_ext_core #(
    .NIB_W  (NIB_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_core (
    .op    (op),
    .wide  (prefix_pending),
    .mode  (mode_e),
    .value (ext_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      imm_out        <= '0;
      prefix_pending <= 1'b0;
      prefix_reg     <= '0;
      prefix_overrun <= 1'b0;
    end else begin
      prefix_overrun <= 1'b0;
      if (flush) begin
        // Flush discards any same-cycle accept, including a prefix.
        out_valid      <= 1'b0;
        prefix_pending <= 1'b0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (accept) begin
          if (mode_e == IMM_PREFIX) begin
            prefix_reg     <= imm8;
            prefix_pending <= 1'b1;
            prefix_overrun <= prefix_pending;
          end else begin
            imm_out        <= ext_value;
            out_valid      <= 1'b1;
            prefix_pending <= 1'b0;
          end
        end
      end
    end
  end

endmodule
